// File: rtl/minisrc_shift_pkg.sv
// rtl/minisrc_shift_pkg.sv - shared op codes, FSM states and sizing helper for the shift/rotate unit
//
// Purpose : Definitions shared by shift_rotate_unit, shift_step and their users.
// Contents: op codes (SHR, SHRA, SHL, ROR, ROL; 5-7 are illegal),
//           state_t (IDLE, SHIFT, DONE),
//           cnt_width() : width of the remaining-count register, clog2(WIDTH)+1.
package minisrc_shift_pkg;

   localparam logic [2:0] SHR  = 3'd0;
   localparam logic [2:0] SHRA = 3'd1;
   localparam logic [2:0] SHL  = 3'd2;
   localparam logic [2:0] ROR  = 3'd3;
   localparam logic [2:0] ROL  = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // The extra bit lets the counter hold WIDTH itself, which a saturated
   // shift needs.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single step: apply op by k positions to one word
//
// Purpose : One step of the shift/rotate datapath.
// Ports   : op       in  3      operation code (minisrc_shift_pkg)
//           k        in  KW     positions to move this step, 0..STEP
//           word_in  in  WIDTH  working value before the step
//           word_out out WIDTH  working value after the step
//           Illegal op codes pass word_in through unchanged.
module shift_step
   import minisrc_shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int KW    = $clog2(WIDTH) + 1
) (
   input  logic [2:0]       op,
   input  logic [KW-1:0]    k,
   input  logic [WIDTH-1:0] word_in,
   output logic [WIDTH-1:0] word_out
);

   logic [KW-1:0] kk;
   logic [KW-1:0] k_inv;

   always_comb begin
      // Defensive clamp; the caller never asks for more than STEP.
      kk    = (k > KW'(STEP)) ? KW'(STEP) : k;
      // Complementary distance for the wrapped-around half of a rotate.
      // With kk=0 this equals WIDTH, and a shift by WIDTH contributes zero.
      k_inv = KW'(WIDTH) - kk;
      case (op)
         SHR:     word_out = word_in >> kk;
         SHRA:    word_out = WIDTH'($signed(word_in) >>> kk);
         SHL:     word_out = word_in << kk;
         ROR:     word_out = (word_in >> kk) | (word_in << k_inv);
         ROL:     word_out = (word_in << kk) | (word_in >> k_inv);
         default: word_out = word_in;
      endcase
   end

endmodule

// File: rtl/shift_rotate_unit.sv
// rtl/shift_rotate_unit.sv - multi-cycle shift/rotate execution unit for the Mini SRC datapath
//
// Purpose : Shifts or rotates a captured operand by up to STEP positions per
//           clock. Pulses done when finished; result is the working register.
// Ports   : clk      in  1      system clock, rising edge
//           clr      in  1      asynchronous active-high reset
//           start    in  1      request, sampled only in IDLE
//           op       in  3      operation code (minisrc_shift_pkg)
//           data_in  in  WIDTH  operand, captured on accepted start
//           amount   in  AMT_W  unsigned count, captured on accepted start
//           busy     out 1      high in SHIFT and DONE
//           done     out 1      one-cycle completion pulse
//           err      out 1      with done: captured op was illegal
//           result   out WIDTH  working register (changes during SHIFT)
module shift_rotate_unit
   import minisrc_shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int AMT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int LOG_W = CNT_W - 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_stepped;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] k;
   logic [CNT_W-1:0] rem_after;
   logic [CNT_W-1:0] eff;
   logic [2:0]       op_q;
   logic             err_q;
   logic             is_rot;
   logic             illegal;
   logic             amt_sat;

   // Effective count from the raw request. Saturation is decided on the
   // full amount before any truncation, so huge shift counts never wrap.
   always_comb begin
      is_rot  = (op == ROR) || (op == ROL);
      illegal = (op > ROL);
      amt_sat = |(amount >> LOG_W);
      if (illegal)
         eff = '0;
      else if (is_rot || !amt_sat)
         eff = {1'b0, amount[LOG_W-1:0]};
      else
         eff = CNT_W'(WIDTH);
   end

   always_comb begin
      k         = (remaining > CNT_W'(STEP)) ? CNT_W'(STEP) : remaining;
      rem_after = remaining - k;
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (CNT_W)
   ) u_step (
      .op       (op_q),
      .k        (k),
      .word_in  (work),
      .word_out (work_stepped)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = (eff == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            if (rem_after == '0)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         work      <= '0;
         remaining <= '0;
         op_q      <= SHR;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work      <= data_in;
                  remaining <= eff;
                  op_q      <= op;
                  err_q     <= illegal;
               end
            end
            SHIFT: begin
               work      <= work_stepped;
               remaining <= rem_after;
            end
            default: ;
         endcase
      end
   end

   // Status decodes straight from the state register so clr clears them
   // without waiting for an edge.
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign err    = (state == DONE) && err_q;
   assign result = work;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb/tb_shift_rotate_unit.sv - directed self-checking bench for shift_rotate_unit (STEP=1 and STEP=4)
module tb_shift_rotate_unit;
   import minisrc_shift_pkg::*;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [2:0]  op;
   logic [31:0] data_in;
   logic [31:0] amount;
   logic        busy1, done1, err1;
   logic        busy4, done4, err4;
   logic [31:0] result1, result4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_rotate_unit #(.WIDTH(32), .STEP(1), .AMT_W(32)) u_dut1 (
      .clk(clk), .clr(clr), .start(start), .op(op), .data_in(data_in),
      .amount(amount), .busy(busy1), .done(done1), .err(err1), .result(result1)
   );

   shift_rotate_unit #(.WIDTH(32), .STEP(4), .AMT_W(32)) u_dut4 (
      .clk(clk), .clr(clr), .start(start), .op(op), .data_in(data_in),
      .amount(amount), .busy(busy4), .done(done4), .err(err4), .result(result4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge, then watch both units until each has
   // pulsed done (bounded). Cycle 1 is the cycle right after the accepting edge.
   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] d,
                      input logic [31:0] a, input logic [31:0] r_exp, input logic e_exp,
                      input int l1_exp, input int l4_exp);
      int          l1, l4;
      logic [31:0] r1, r4;
      logic        e1, e4;
      l1 = 0; l4 = 0; r1 = '0; r4 = '0; e1 = 1'b0; e4 = 1'b0;
      @(negedge clk);
      op = o; data_in = d; amount = a; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_c1"}, 32'(busy1), 32'd1);
      for (int n = 1; n <= 45 && (l1 == 0 || l4 == 0); n++) begin
         if (n > 1) begin
            @(posedge clk);
            #1;
         end
         if (done1 && l1 == 0) begin l1 = n; r1 = result1; e1 = err1; end
         if (done4 && l4 == 0) begin l4 = n; r4 = result4; e4 = err4; end
      end
      check({tag, "_lat_s1"}, 32'(l1), 32'(l1_exp));
      check({tag, "_res_s1"}, r1, r_exp);
      check({tag, "_err_s1"}, 32'(e1), 32'(e_exp));
      check({tag, "_lat_s4"}, 32'(l4), 32'(l4_exp));
      check({tag, "_res_s4"}, r4, r_exp);
      check({tag, "_err_s4"}, 32'(e4), 32'(e_exp));
      @(posedge clk);
      #1;
      check({tag, "_done_low"}, 32'({done1, busy1}), 32'd0);
      check({tag, "_hold_s1"}, result1, r_exp);
   endtask

   initial begin
      int n;
      clr = 1'b1; start = 1'b0; op = SHR; data_in = '0; amount = '0;
      #3;
      check("reset_busy", 32'(busy1), 32'd0);
      check("reset_done", 32'(done1), 32'd0);
      check("reset_err", 32'(err1), 32'd0);
      check("reset_result", result1, 32'd0);
      @(negedge clk);
      clr = 1'b0;

      run("rol_40",     ROL,  32'h8000FA92, 32'h28,       32'h00FA9280, 1'b0,  9, 3);
      run("ror_4",      ROR,  32'h00000595, 32'd4,        32'h50000059, 1'b0,  5, 2);
      run("shra_40",    SHRA, 32'h80000000, 32'd40,       32'hFFFFFFFF, 1'b0, 33, 9);
      run("shr_40",     SHR,  32'h80000000, 32'd40,       32'h00000000, 1'b0, 33, 9);
      run("shl_0",      SHL,  32'h00001234, 32'd0,        32'h00001234, 1'b0,  1, 1);
      run("illegal7",   3'd7, 32'hDEADBEEF, 32'd5,        32'hDEADBEEF, 1'b1,  1, 1);
      run("ror_64",     ROR,  32'h12345678, 32'd64,       32'h12345678, 1'b0,  1, 1);
      run("shl_31",     SHL,  32'h00000001, 32'd31,       32'h80000000, 1'b0, 32, 9);
      run("shr_nowrap", SHR,  32'hF0000000, 32'h41,       32'h00000000, 1'b0, 33, 9);
      run("shra_3",     SHRA, 32'h87654321, 32'd3,        32'hF0ECA864, 1'b0,  4, 2);
      run("rol_33",     ROL,  32'h12345678, 32'd33,       32'h2468ACF0, 1'b0,  2, 2);

      // Second start during SHIFT must be ignored by the STEP=1 unit.
      @(negedge clk);
      op = SHL; data_in = 32'h1; amount = 32'd10; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      op = ROR; data_in = 32'h0000FFFF; amount = 32'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 5;
      while (!done1 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ignore_start_lat", 32'(n), 32'd11);
      check("ignore_start_res", result1, 32'h00000400);

      // Asynchronous clear in the middle of SHIFT.
      repeat (3) @(posedge clk);
      @(negedge clk);
      op = SHR; data_in = 32'hFFFFFFFF; amount = 32'd20; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      clr = 1'b1;
      #1;
      check("clr_busy1", 32'(busy1), 32'd0);
      check("clr_done1", 32'(done1), 32'd0);
      check("clr_result1", result1, 32'd0);
      check("clr_busy4", 32'(busy4), 32'd0);
      check("clr_result4", result4, 32'd0);
      @(negedge clk);
      clr = 1'b0;
      run("post_clr_ror", ROR, 32'h00000595, 32'd4, 32'h50000059, 1'b0, 5, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
